// File: rtl/controller_if.sv
// Datapath-facing bus of the accumulator CPU sequencer: opcode/zero in, phase and strobes out.
interface controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       mem_rd;
    logic       load_ir;
    logic       halt;
    logic       inc_pc;
    logic       load_ac;
    logic       load_pc;
    logic       mem_wr;

    // Sequencer side
    modport master (
        input  opcode, zero,
        output phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr
    );

    // Datapath side
    modport slave (
        output opcode, zero,
        input  phase, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr
    );
endinterface

// File: rtl/controller.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// Strobes are combinational decodes of phase/opcode/zero/halted so the
// datapath sees them in the same cycle as the phase they belong to.
module controller (
    input  logic         clk,
    input  logic         rst,
    controller_if.master bus
);
    localparam int unsigned PHASE_W = 3;
    localparam int unsigned OP_W    = 3;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [OP_W-1:0] OP_HLT = 3'd0;
    localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_LDA = 3'd5;
    localparam logic [OP_W-1:0] OP_STO = 3'd6;
    localparam logic [OP_W-1:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    logic   aluop;
    logic   is_hlt;
    logic   mem_rd_c, load_ir_c, halt_c, inc_pc_c, load_ac_c, load_pc_c, mem_wr_c;

    // Opcode classes used by the late phases
    assign aluop  = bus.opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    assign is_hlt = (bus.opcode == OP_HLT);

    // Phase counter and sticky halt flag; reset is immediate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next phase and strobe decode; a halted machine parks in OP_ADDR
    always_comb begin
        phase_d   = phase_q;
        halted_d  = halted_q;
        mem_rd_c  = 1'b0;
        load_ir_c = 1'b0;
        halt_c    = 1'b0;
        inc_pc_c  = 1'b0;
        load_ac_c = 1'b0;
        load_pc_c = 1'b0;
        mem_wr_c  = 1'b0;

        if (halted_q) begin
            halt_c = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    phase_d = INST_FETCH;
                end
                INST_FETCH: begin
                    phase_d  = INST_LOAD;
                    mem_rd_c = 1'b1;
                end
                INST_LOAD: begin
                    phase_d   = IDLE;
                    mem_rd_c  = 1'b1;
                    load_ir_c = 1'b1;
                end
                IDLE: begin
                    phase_d   = OP_ADDR;
                    mem_rd_c  = 1'b1;
                    load_ir_c = 1'b1;
                end
                OP_ADDR: begin
                    // HLT holds the PC on itself and freezes the phase here
                    if (is_hlt) begin
                        halted_d = 1'b1;
                        halt_c   = 1'b1;
                    end else begin
                        phase_d  = OP_FETCH;
                        inc_pc_c = 1'b1;
                    end
                end
                OP_FETCH: begin
                    phase_d  = ALU_OP;
                    mem_rd_c = aluop;
                end
                ALU_OP: begin
                    phase_d   = STORE;
                    mem_rd_c  = aluop;
                    load_ac_c = aluop;
                    inc_pc_c  = (bus.opcode == OP_SKZ) && bus.zero;
                    load_pc_c = (bus.opcode == OP_JMP);
                end
                STORE: begin
                    phase_d   = INST_ADDR;
                    mem_rd_c  = aluop;
                    load_ac_c = aluop;
                    inc_pc_c  = (bus.opcode == OP_JMP);
                    load_pc_c = (bus.opcode == OP_JMP);
                    mem_wr_c  = (bus.opcode == OP_STO);
                end
                default: begin
                    phase_d = INST_ADDR;
                end
            endcase
        end
    end

    // Drive the bus
    assign bus.phase   = PHASE_W'(phase_q);
    assign bus.mem_rd  = mem_rd_c;
    assign bus.load_ir = load_ir_c;
    assign bus.halt    = halt_c;
    assign bus.inc_pc  = inc_pc_c;
    assign bus.load_ac = load_ac_c;
    assign bus.load_pc = load_pc_c;
    assign bus.mem_wr  = mem_wr_c;
endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the accumulator CPU sequencer.
module tb_controller;
    logic clk;
    logic rst;
    controller_if bus ();

    controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state
    int m_phase  = 0;
    bit m_halted = 1'b0;

    int cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
    function automatic logic [6:0] exp_out(input int ph, input logic [2:0] op, input logic z, input bit hlt);
        bit rd, ir, hl, pc, ac, lp, wr;
        bit is_alu;
        rd = 0; ir = 0; hl = 0; pc = 0; ac = 0; lp = 0; wr = 0;
        if (hlt) begin
            hl = 1;
        end else if (ph == 1) begin
            rd = 1;
        end else if (ph == 2 || ph == 3) begin
            rd = 1; ir = 1;
        end else if (ph >= 4) begin
            is_alu = (op === 3'd2) || (op === 3'd3) || (op === 3'd4) || (op === 3'd5);
            if (ph == 4) begin
                hl = (op === 3'd0);
                pc = !hl;
            end else if (ph == 5) begin
                rd = is_alu;
            end else if (ph == 6) begin
                rd = is_alu; ac = is_alu;
                pc = (op === 3'd1) && (z === 1'b1);
                lp = (op === 3'd7);
            end else begin
                rd = is_alu; ac = is_alu;
                pc = (op === 3'd7); lp = (op === 3'd7);
                wr = (op === 3'd6);
            end
        end
        return {rd, ir, hl, pc, ac, lp, wr};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.phase, bus.mem_rd, bus.load_ir, bus.halt, bus.inc_pc,
                bus.load_ac, bus.load_pc, bus.mem_wr};
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b (phase,rd,ir,halt,inc,ac,ldpc,wr)", tag, obs, exp);
    endtask

    task automatic check_now(input string tag);
        check(tag, observed(), {3'(m_phase), exp_out(m_phase, bus.opcode, bus.zero, m_halted)});
    endtask

    // One rising edge: advance the model, then sample just after the edge
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst) begin
            if (m_halted) begin
                m_phase = m_phase;
            end else if (m_phase == 4 && bus.opcode === 3'd0) begin
                m_halted = 1'b1;
            end else begin
                m_phase = (m_phase + 1) % 8;
            end
        end
        #1 check_now(tag);
    endtask

    task automatic set_in(input logic [2:0] op, input logic z, input string tag);
        bus.opcode = op;
        bus.zero   = z;
        #1 check_now(tag);
    endtask

    // Reset pulse between clock edges, no edge needed to take effect
    task automatic async_rst(input string tag);
        #2 rst = 1'b1;
        m_phase  = 0;
        m_halted = 1'b0;
        #1 check_now(tag);
        #1 rst = 1'b0;
    endtask

    // Reset held across one rising edge, then released
    task automatic do_reset();
        #2 rst = 1'b1;
        m_phase  = 0;
        m_halted = 1'b0;
        #1 check_now("rst_async");
        tick("rst_hold");
        rst = 1'b0;
    endtask

    // Safety net so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no completion, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
        #1 check_now("t1_rst0");

        // 1: reset held two cycles, then 16 free-running cycles of ADD
        tick("t1_rst1");
        tick("t1_rst2");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tick("t1_run");

        // 2: SKZ with zero=1 gives two PC increments, zero=0 gives one
        do_reset();
        set_in(3'd1, 1'b1, "t2_set");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick("t2_skz1");
            cnt += int'(bus.inc_pc);
        end
        check("t2_incs_z1", 10'(cnt), 10'd2);
        set_in(3'd1, 1'b0, "t2_set0");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick("t2_skz0");
            cnt += int'(bus.inc_pc);
        end
        check("t2_incs_z0", 10'(cnt), 10'd1);

        // 3: JMP then STO
        do_reset();
        set_in(3'd7, 1'b0, "t3_jmp_set");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick("t3_jmp");
            cnt += int'(bus.load_pc);
        end
        check("t3_jmp_ldpc", 10'(cnt), 10'd2);
        do_reset();
        set_in(3'd6, 1'b1, "t3_sto_set");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick("t3_sto");
            cnt += int'(bus.mem_wr);
        end
        check("t3_sto_wr", 10'(cnt), 10'd1);

        // 4: HLT parks in phase 4 until reset
        do_reset();
        set_in(3'd0, 1'b0, "t4_set");
        for (int i = 0; i < 4; i++) tick("t4_to4");
        check("t4_halt_at4", {bus.phase, bus.halt, bus.inc_pc, 5'd0}, {3'd4, 1'b1, 1'b0, 5'd0});
        for (int i = 0; i < 20; i++) tick("t4_hold");
        set_in(3'd2, 1'b1, "t4_add");
        for (int i = 0; i < 5; i++) tick("t4_hold_add");
        check("t4_still_halted", {bus.phase, bus.halt, 6'd0}, {3'd4, 1'b1, 6'd0});
        async_rst("t4_async");
        tick("t4_resume");

        // 5: mid-instruction reset during LDA ALU_OP
        do_reset();
        set_in(3'd5, 1'b0, "t5_set");
        for (int i = 0; i < 6; i++) tick("t5_to6");
        check("t5_at6", {bus.phase, bus.load_ac, 6'd0}, {3'd6, 1'b1, 6'd0});
        async_rst("t5_async");
        tick("t5_next");
        check("t5_phase1", 10'(bus.phase), 10'd1);

        // 6: all opcodes x zero, rd/wr exclusion and load_ir placement
        for (int op = 0; op < 8; op++) begin
            for (int z = 0; z < 2; z++) begin
                do_reset();
                set_in(3'(op), 1'(z), "t6_set");
                for (int i = 0; i < 8; i++) begin
                    tick("t6_sweep");
                    check("t6_excl", 10'(bus.mem_rd & bus.mem_wr), 10'd0);
                    check("t6_ir", 10'(bus.load_ir), 10'((m_phase == 2 || m_phase == 3) ? 1 : 0));
                end
            end
        end

        // Random traffic with occasional resets and unknown inputs during IR reload
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick("rand");
            if ($urandom_range(0, 49) == 0 || (m_halted && $urandom_range(0, 3) == 0)) begin
                do_reset();
            end else if (m_phase <= 2 && $urandom_range(0, 7) == 0) begin
                set_in(3'bxxx, 1'bx, "rand_x");
            end else begin
                set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand_in");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
